// File: rtl/alu_pkg.sv
// Shared types and widths for the ALU operand sequencer and its button front end.
package alu_pkg;

   localparam int WIDTH_DEF = 8;
   localparam int OP_W      = 4;

   typedef enum logic [1:0] {
      LOAD_A = 2'd0,
      LOAD_B = 2'd1,
      EXEC   = 2'd2,
      SHOW   = 2'd3
   } state_t;

endpackage

// File: rtl/button_debounce.sv
// Execute-button front end: 2-flop synchronizer, stability counter, and a
// one-cycle press pulse on the debounced rising edge.
module button_debounce #(
   parameter int DEBOUNCE_CYCLES = 4
) (
   input  logic clock,
   input  logic reset,
   input  logic btn_raw,
   output logic press
);

   localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

   logic          sync1, sync2;
   logic          level, level_q;
   logic [CW-1:0] cnt;

   always_ff @(posedge clock) begin
      if (!reset) begin
         sync1   <= 1'b0;
         sync2   <= 1'b0;
         level   <= 1'b0;
         level_q <= 1'b0;
         cnt     <= '0;
      end else begin
         sync1   <= btn_raw;
         sync2   <= sync1;
         level_q <= level;
         // Any sample agreeing with the accepted level restarts the count.
         if (sync2 == level) begin
            cnt <= '0;
         end else if (cnt == CW'(DEBOUNCE_CYCLES)) begin
            level <= sync2;
            cnt   <= '0;
         end else begin
            cnt <= cnt + 1'b1;
         end
      end
   end

   assign press = level & ~level_q;

endmodule

// File: rtl/alu_sequencer.sv
// Load-A / load-B / execute / show controller around an external ALU mux,
// driven by a single debounced execute button.
module alu_sequencer
   import alu_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 4,
   parameter int WIDTH           = WIDTH_DEF
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             btn_raw,
   input  logic             chain,
   input  logic [WIDTH-1:0] data_in,
   input  logic [OP_W-1:0]  op_in,
   input  logic [WIDTH-1:0] alu_y,
   output logic [WIDTH-1:0] a_out,
   output logic [WIDTH-1:0] b_out,
   output logic [OP_W-1:0]  op_out,
   output logic [WIDTH-1:0] y_out,
   output logic [1:0]       state_out,
   output logic             done
);

   state_t state;
   logic   press;

   button_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
   ) u_debounce (
      .clock  (clock),
      .reset  (reset),
      .btn_raw(btn_raw),
      .press  (press)
   );

   always_ff @(posedge clock) begin
      if (!reset) begin
         state  <= LOAD_A;
         a_out  <= '0;
         b_out  <= '0;
         op_out <= '0;
         y_out  <= '0;
         done   <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            LOAD_A: if (press) begin
               a_out <= data_in;
               state <= LOAD_B;
            end
            LOAD_B: if (press) begin
               b_out  <= data_in;
               op_out <= op_in;
               state  <= EXEC;
            end
            // A press landing here is dropped; the pulse is gone next cycle.
            EXEC: begin
               y_out <= alu_y;
               done  <= 1'b1;
               state <= SHOW;
            end
            SHOW: if (press) begin
               if (chain) begin
                  a_out <= y_out;
                  state <= LOAD_B;
               end else begin
                  state <= LOAD_A;
               end
            end
            default: state <= LOAD_A;
         endcase
      end
   end

   assign state_out = state;

endmodule

// File: tb/tb_alu_sequencer.sv
// Bench for alu_sequencer: vector table plus hand sequences, results checked
// through a done-driven scoreboard against a small behavioural ALU.
module tb_alu_sequencer;

   localparam int D = 4;
   localparam int W = 8;

   logic         clock = 1'b0;
   logic         reset = 1'b0;
   logic         btn_raw = 1'b0;
   logic         chain = 1'b0;
   logic [W-1:0] data_in = '0;
   logic [3:0]   op_in = '0;
   logic [W-1:0] alu_y;
   logic [W-1:0] a_out, b_out, y_out;
   logic [3:0]   op_out;
   logic [1:0]   state_out;
   logic         done;

   int checks = 0;
   int errors = 0;
   logic [W-1:0] exp_q[$];

   always #5 clock = ~clock;

   alu_sequencer #(.DEBOUNCE_CYCLES(D), .WIDTH(W)) dut (
      .clock    (clock),
      .reset    (reset),
      .btn_raw  (btn_raw),
      .chain    (chain),
      .data_in  (data_in),
      .op_in    (op_in),
      .alu_y    (alu_y),
      .a_out    (a_out),
      .b_out    (b_out),
      .op_out   (op_out),
      .y_out    (y_out),
      .state_out(state_out),
      .done     (done)
   );

   function automatic logic [W-1:0] alu_model(input logic [3:0] op,
                                              input logic [W-1:0] a, b);
      case (op)
         4'h1:    return a + b;
         4'h7:    return a - b;
         default: return a ^ b;
      endcase
   endfunction

   assign alu_y = alu_model(op_out, a_out, b_out);

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Each done pulse must match the oldest outstanding expected result.
   always @(negedge clock) begin
      if (reset && done) begin
         if (exp_q.size() == 0) chk("done_unexpected", 1, 0);
         else chk("y_out_on_done", y_out, exp_q.pop_front());
      end
   end

   task automatic cycles(input int n);
      repeat (n) @(negedge clock);
   endtask

   task automatic press_btn(input logic [W-1:0] d, input logic [3:0] op);
      data_in = d;
      op_in   = op;
      btn_raw = 1'b1;
      cycles(D + 4);
      btn_raw = 1'b0;
      cycles(D + 4);
   endtask

   typedef struct {
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic [3:0]   op;
      logic [W-1:0] y;
   } vec_t;

   vec_t vecs[4];
   logic [1:0] st_before;
   bit seen;

   initial begin
      vecs[0] = '{a: 8'h05, b: 8'h03, op: 4'h1, y: 8'h08};
      vecs[1] = '{a: 8'hff, b: 8'h01, op: 4'h1, y: 8'h00};
      vecs[2] = '{a: 8'h10, b: 8'h20, op: 4'h7, y: 8'hf0};
      vecs[3] = '{a: 8'haa, b: 8'h0f, op: 4'h2, y: 8'ha5};

      cycles(3);
      chk("rst_state", state_out, 0);
      chk("rst_outs", {a_out, b_out, y_out, op_out, done}, 0);
      reset = 1'b1;
      cycles(2);

      // Exact press latency: update lands on edge D+3 counted from first high sample.
      data_in = 8'h12;
      btn_raw = 1'b1;
      cycles(D + 3);
      chk("lat_before", state_out, 0);
      cycles(1);
      chk("lat_state", state_out, 1);
      chk("lat_a", a_out, 8'h12);
      btn_raw = 1'b0;
      cycles(D + 4);

      // Reset mid LOAD_B.
      reset = 1'b0;
      cycles(1);
      reset = 1'b1;
      chk("midB_rst_state", state_out, 0);
      chk("midB_rst_outs", {a_out, b_out, y_out, op_out, done}, 0);
      cycles(2);

      for (int i = 0; i < 4; i++) begin
         chain = 1'b0;
         press_btn(vecs[i].a, 4'h0);
         exp_q.push_back(vecs[i].y);
         press_btn(vecs[i].b, vecs[i].op);
         chk($sformatf("v%0d_a", i), a_out, vecs[i].a);
         chk($sformatf("v%0d_b", i), b_out, vecs[i].b);
         chk($sformatf("v%0d_op", i), op_out, vecs[i].op);
         chk($sformatf("v%0d_y", i), y_out, vecs[i].y);
         chk($sformatf("v%0d_state", i), state_out, 3);
         press_btn(8'h00, 4'h0);
         chk($sformatf("v%0d_back", i), state_out, 0);
         chk($sformatf("v%0d_ahold", i), a_out, vecs[i].a);
      end

      // Chain and opcode isolation.
      press_btn(8'h05, 4'h0);
      exp_q.push_back(8'h08);
      press_btn(8'h03, 4'h1);
      op_in = 4'h7;
      cycles(3);
      chk("show_op_hold", op_out, 1);
      chain = 1'b1;
      press_btn(8'h55, 4'h7);
      chk("chain_state", state_out, 1);
      chk("chain_a", a_out, 8'h08);
      chk("chain_op_hold", op_out, 1);
      exp_q.push_back(8'h06);
      press_btn(8'h02, 4'h7);
      chk("chain_y", y_out, 8'h06);
      chk("chain_op_new", op_out, 7);
      chain = 1'b0;
      press_btn(8'h00, 4'h1);
      chk("unchain_state", state_out, 0);
      chk("unchain_a", a_out, 8'h08);
      press_btn(8'h09, 4'h3);
      chk("loadA_op_hold", op_out, 7);
      chk("loadA_state", state_out, 1);
      exp_q.push_back(8'h0a);
      press_btn(8'h01, 4'h1);
      chk("seq3_y", y_out, 8'h0a);
      press_btn(8'h00, 4'h0);
      chk("seq3_back", state_out, 0);

      // Bounce: glitches of D-1 samples never reach the level.
      st_before = state_out;
      for (int k = 0; k < 3; k++) begin
         btn_raw = 1'b1;
         cycles(D - 1);
         btn_raw = 1'b0;
         cycles(2);
      end
      cycles(D + 2);
      chk("bounce_nopress", state_out, st_before);
      data_in = 8'h33;
      btn_raw = 1'b1;
      cycles(3 * D);
      chk("stable_one_press", state_out, 1);
      chk("stable_a", a_out, 8'h33);
      btn_raw = 1'b0;
      cycles(D + 4);

      // Reset landing on the EXEC cycle; button still held through it.
      reset = 1'b0;
      cycles(1);
      reset = 1'b1;
      cycles(1);
      press_btn(8'h21, 4'h0);
      data_in = 8'h44;
      op_in   = 4'h1;
      btn_raw = 1'b1;
      seen = 0;
      for (int t = 0; t < 4 * D + 10 && !seen; t++) begin
         @(negedge clock);
         if (state_out == 2) seen = 1;
      end
      chk("exec_reached", seen, 1);
      reset = 1'b0;
      @(negedge clock);
      reset = 1'b1;
      chk("exec_rst_state", state_out, 0);
      chk("exec_rst_y", y_out, 0);
      chk("exec_rst_done", done, 0);
      cycles(2);
      chk("held_wait", state_out, 0);
      cycles(D + 4);
      chk("held_repress", state_out, 1);
      chk("held_a", a_out, 8'h44);
      btn_raw = 1'b0;
      cycles(D + 4);

      chk("scoreboard_empty", exp_q.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
